// File: rtl/psp_arb_pkg.sv
// Shared types for the PSP memory arbiter.
// State, requester ids and the latched memory command.
package psp_arb_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;

    typedef enum logic {
        FETCH,
        DATA
    } arb_req_t;

    typedef struct packed {
        logic        read;
        logic        write;
        logic [31:0] addr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/psp_arb_rr.sv
// Two-way round-robin picker for the memory arbiter.
// On a tie the requester not granted last time wins.
module psp_arb_rr
    import psp_arb_pkg::*;
(
    input  logic     fetch_pend,
    input  logic     data_pend,
    input  arb_req_t last_grant,
    output logic     gnt_valid,
    output arb_req_t gnt_id
);

    // pick a winner among the pending requesters
    always_comb begin
        gnt_valid = fetch_pend | data_pend;
        gnt_id    = DATA;
        if (fetch_pend && data_pend) begin
            gnt_id = (last_grant == DATA) ? FETCH : DATA;
        end else if (fetch_pend) begin
            gnt_id = FETCH;
        end
    end

endmodule

// File: rtl/psp_mem_arbiter.sv
// Fetch/data arbiter for the PSP unified memory port.
// PSP_ARB_TIMEOUT_EN builds a hang watchdog (TIMEOUT cycles).
module psp_mem_arbiter
    import psp_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_read,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_resp,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_wmask,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        timeout_err
);

    arb_state_t state_q, state_d;
    arb_req_t   last_q, last_d;
    arb_req_t   win_q, win_d;
    mem_cmd_t   cmd_q, cmd_d;
    mem_cmd_t   fetch_cmd, data_cmd;
    logic       gnt_valid;
    arb_req_t   gnt_id;
    logic       done;
    logic       abort;
    logic       live;

`ifdef PSP_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT);
`endif

    psp_arb_rr u_rr (
        .fetch_pend (if_read),
        .data_pend  (d_read | d_write),
        .last_grant (last_q),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    // candidate commands; read+write together is issued as a write
    always_comb begin
        fetch_cmd       = '0;
        fetch_cmd.read  = 1'b1;
        fetch_cmd.addr  = if_addr;
        data_cmd        = '0;
        data_cmd.read   = d_read & ~d_write;
        data_cmd.write  = d_write;
        data_cmd.addr   = d_addr;
        data_cmd.wmask  = d_write ? d_wmask : 4'b0;
        data_cmd.wdata  = d_wdata;
    end

    // next-state: grant in IDLE, complete or abort in BUSY
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        cmd_d   = cmd_q;
        done    = 1'b0;
        abort   = 1'b0;
`ifdef PSP_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef PSP_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (gnt_valid) begin
                    state_d = BUSY;
                    last_d  = gnt_id;
                    win_d   = gnt_id;
                    cmd_d   = (gnt_id == FETCH) ? fetch_cmd : data_cmd;
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
`ifdef PSP_ARB_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    abort   = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // drive the memory port from the latch, route the response back
    always_comb begin
        live      = (state_q == BUSY) & ~abort;
        mem_read  = live & cmd_q.read;
        mem_write = live & cmd_q.write;
        mem_addr  = live ? cmd_q.addr : 32'b0;
        mem_wmask = live ? cmd_q.wmask : 4'b0;
        mem_wdata = live ? cmd_q.wdata : 32'b0;
        if_resp   = (done | abort) & (win_q == FETCH);
        d_resp    = (done | abort) & (win_q == DATA);
        if_rdata  = (done & cmd_q.read & (win_q == FETCH)) ?
                    mem_rdata : 32'b0;
        d_rdata   = (done & cmd_q.read & (win_q == DATA)) ?
                    mem_rdata : 32'b0;
    end

    // arbiter state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= DATA;
            win_q   <= FETCH;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            cmd_q   <= cmd_d;
        end
    end

`ifdef PSP_ARB_TIMEOUT_EN
    // watchdog counter and sticky error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign timeout_err = err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
